// File: rtl/membus_pkg.sv
// -----------------------------------------------------------------------------
// membus_pkg
// Shared definitions for the two-master data memory bus arbiter.
//   owner_e           : bus owner encoding (NONE / M0 / M1)
//   MEM_LIMIT_DEFAULT : first device-space address; everything below is
//                       DataMemory. The CPU address decode uses the same value.
// -----------------------------------------------------------------------------
package membus_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_M0   = 2'b01,
      OWN_M1   = 2'b10
   } owner_e;

   localparam logic [31:0] MEM_LIMIT_DEFAULT = 32'h4000_0000;

endpackage

// File: rtl/membus_route.sv
// -----------------------------------------------------------------------------
// membus_route
// Combinational address decode for the shared bus: raises the DataMemory or
// device strobe for the current transfer and selects the read data source.
// Ports:
//   xfer_i        : a transfer is taking place this cycle
//   write_i       : 1 = write, 0 = read (from the owning master)
//   addr_i        : muxed bus address
//   mem_rdata_i   : DataMemory read data
//   dev_rdata_i   : device read data
//   mem_read_o / mem_write_o / dev_read_o / dev_write_o : access strobes
//   rdata_o       : read data picked by the same address decode
// -----------------------------------------------------------------------------
module membus_route
   import membus_pkg::*;
#(
   parameter int                 DATA_W    = 32,
   parameter int                 ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]  MEM_LIMIT = ADDR_W'(MEM_LIMIT_DEFAULT)
) (
   input  logic              xfer_i,
   input  logic              write_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic [DATA_W-1:0] dev_rdata_i,
   output logic              mem_read_o,
   output logic              mem_write_o,
   output logic              dev_read_o,
   output logic              dev_write_o,
   output logic [DATA_W-1:0] rdata_o
);

   logic is_mem;

   assign is_mem      = (addr_i < MEM_LIMIT);
   assign mem_read_o  = xfer_i &  is_mem & ~write_i;
   assign mem_write_o = xfer_i &  is_mem &  write_i;
   assign dev_read_o  = xfer_i & ~is_mem & ~write_i;
   assign dev_write_o = xfer_i & ~is_mem &  write_i;
   assign rdata_o     = is_mem ? mem_rdata_i : dev_rdata_i;

endmodule

// File: rtl/membus_arbiter.sv
// -----------------------------------------------------------------------------
// membus_arbiter
// Two-master arbiter for the shared data memory bus. Master 0 is the CPU data
// port, master 1 the DMA/loader engine. One owner per cycle; the owner's
// access is routed to DataMemory or device space by address, and read data is
// returned registered to the master that issued the read.
//
// Build option:
//   MEMBUS_ARB_PRIO_EN : defined   -> fixed priority, M0 wins ties and
//                                     preempts an unlocked M1 owner; MAX_HOLD
//                                     limits M0 only.
//                        undefined -> round-robin with MAX_HOLD fairness.
//
// Ports:
//   clk, reset (async, active-low)
//   mN_req/write/lock/addr/wdata : master N request side
//   mN_gnt, mN_rvalid, mN_rdata  : master N response side
//   mem_read/mem_write, dev_read/dev_write : memory / device strobes
//   bus_addr, bus_wdata          : muxed address / write data (0 when idle)
//   mem_rdata, dev_rdata         : combinational read data from the slaves
// -----------------------------------------------------------------------------
module membus_arbiter
   import membus_pkg::*;
#(
   parameter int                 DATA_W    = 32,
   parameter int                 ADDR_W    = 32,
   parameter int                 MAX_HOLD  = 8,
   parameter logic [ADDR_W-1:0]  MEM_LIMIT = ADDR_W'(MEM_LIMIT_DEFAULT)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_write,
   input  logic              m0_lock,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_write,
   input  logic              m1_lock,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic              dev_read,
   output logic              dev_write,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [DATA_W-1:0] dev_rdata
);

   localparam int              HW       = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0]   HOLD_MAX = HW'(MAX_HOLD);

   owner_e            owner_q, owner_d;
   owner_e            rr_last_q, rr_last_d;
   logic [HW-1:0]     hold_q, hold_d, hold_inc;
   logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

   logic              xfer0, xfer1, xfer;
   logic              bus_write;
   logic [DATA_W-1:0] route_rdata;
   logic              stay0, stay1;

   assign m0_gnt    = (owner_q == OWN_M0);
   assign m1_gnt    = (owner_q == OWN_M1);
   assign m0_rvalid = rvalid0_q;
   assign m1_rvalid = rvalid1_q;
   assign m0_rdata  = rdata0_q;
   assign m1_rdata  = rdata1_q;

   assign xfer0 = m0_req & m0_gnt;
   assign xfer1 = m1_req & m1_gnt;
   assign xfer  = xfer0 | xfer1;

   // Bus mux: idle bus drives zeros so nothing leaks onto the slaves.
   always_comb begin
      bus_write = 1'b0;
      bus_addr  = '0;
      bus_wdata = '0;
      if (xfer0) begin
         bus_write = m0_write;
         bus_addr  = m0_addr;
         bus_wdata = m0_wdata;
      end else if (xfer1) begin
         bus_write = m1_write;
         bus_addr  = m1_addr;
         bus_wdata = m1_wdata;
      end
   end

   membus_route #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .MEM_LIMIT (MEM_LIMIT)
   ) u_route (
      .xfer_i      (xfer),
      .write_i     (bus_write),
      .addr_i      (bus_addr),
      .mem_rdata_i (mem_rdata),
      .dev_rdata_i (dev_rdata),
      .mem_read_o  (mem_read),
      .mem_write_o (mem_write),
      .dev_read_o  (dev_read),
      .dev_write_o (dev_write),
      .rdata_o     (route_rdata)
   );

   // The hold count includes the transfer completing at this edge, so an
   // owner gets exactly MAX_HOLD back-to-back transfers before yielding.
   assign hold_inc = (xfer && (hold_q < HOLD_MAX)) ? hold_q + 1'b1 : hold_q;

   assign stay0 = m0_lock | ~m1_req | (hold_inc < HOLD_MAX);
`ifdef MEMBUS_ARB_PRIO_EN
   // An unlocked M1 owner is preempted as soon as M0 asks.
   assign stay1 = m1_lock | ~m0_req;
`else
   assign stay1 = m1_lock | ~m0_req | (hold_inc < HOLD_MAX);
`endif

   always_comb begin
      owner_d   = OWN_NONE;
      rr_last_d = rr_last_q;
      hold_d    = hold_inc;

      case (owner_q)
         OWN_M0: begin
            if (m0_req && stay0)  owner_d = OWN_M0;
            else if (m1_req)      owner_d = OWN_M1;
         end
         OWN_M1: begin
            if (m1_req && stay1)  owner_d = OWN_M1;
            else if (m0_req)      owner_d = OWN_M0;
         end
         default: begin
            if (m0_req && m1_req) begin
`ifdef MEMBUS_ARB_PRIO_EN
               owner_d = OWN_M0;
`else
               owner_d = (rr_last_q == OWN_M0) ? OWN_M1 : OWN_M0;
`endif
            end else if (m0_req) begin
               owner_d = OWN_M0;
            end else if (m1_req) begin
               owner_d = OWN_M1;
            end
         end
      endcase

      if (owner_d != owner_q) begin
         hold_d = '0;
         if (owner_d != OWN_NONE) rr_last_d = owner_d;
      end
   end

   // Read response: one-cycle pulse to the issuing master, data held after.
   always_comb begin
      rvalid0_d = xfer0 & ~m0_write;
      rvalid1_d = xfer1 & ~m1_write;
      rdata0_d  = rvalid0_d ? route_rdata : rdata0_q;
      rdata1_d  = rvalid1_d ? route_rdata : rdata1_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner_q   <= OWN_NONE;
         rr_last_q <= OWN_M1;
         hold_q    <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         owner_q   <= owner_d;
         rr_last_q <= rr_last_d;
         hold_q    <= hold_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end

endmodule

// File: tb/tb_membus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_membus_arbiter
// Directed bench for membus_arbiter: a vector table for single-transfer
// behaviour plus hand-written sequences for fairness, locked bursts,
// preemption and asynchronous reset. Expectations follow the build option
// MEMBUS_ARB_PRIO_EN where the two arbitration modes differ.
// -----------------------------------------------------------------------------
module tb_membus_arbiter;

   localparam logic [31:0] DB = 32'hDEAD_BEEF;
   localparam logic [31:0] DV = 32'h1234_5678;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_write, m0_lock, m1_req, m1_write, m1_lock;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_read, mem_write, dev_read, dev_write;
   logic [31:0] bus_addr, bus_wdata;
   logic [31:0] mem_rdata, dev_rdata;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   membus_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .m0_req    (m0_req),
      .m0_write  (m0_write),
      .m0_lock   (m0_lock),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m0_gnt    (m0_gnt),
      .m0_rvalid (m0_rvalid),
      .m0_rdata  (m0_rdata),
      .m1_req    (m1_req),
      .m1_write  (m1_write),
      .m1_lock   (m1_lock),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_gnt    (m1_gnt),
      .m1_rvalid (m1_rvalid),
      .m1_rdata  (m1_rdata),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .dev_read  (dev_read),
      .dev_write (dev_write),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .mem_rdata (mem_rdata),
      .dev_rdata (dev_rdata)
   );

   typedef struct {
      logic        r0, r1, w0, w1;
      logic [31:0] a0, a1, d0, d1;
      logic        g0, g1;
      logic [3:0]  strb;          // {mem_read, mem_write, dev_read, dev_write}
      logic [31:0] baddr, bwdata;
      logic        v0, v1;
      logic [31:0] rd0, rd1;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic r0, r1, w0, w1,
      input logic [31:0] a0, a1, d0, d1,
      input logic g0, g1, input logic [3:0] strb,
      input logic [31:0] baddr, bwdata,
      input logic v0, v1, input logic [31:0] rd0, rd1);
      vec_t v;
      v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
      v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
      v.g0 = g0; v.g1 = g1; v.strb = strb;
      v.baddr = baddr; v.bwdata = bwdata;
      v.v0 = v0; v.v1 = v1; v.rd0 = rd0; v.rd1 = rd1;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic set_in(input logic r0, r1, l0, l1, w0, w1,
                         input logic [31:0] a0, a1, d0, d1);
      m0_req = r0; m1_req = r1; m0_lock = l0; m1_lock = l1;
      m0_write = w0; m1_write = w1;
      m0_addr = a0; m1_addr = a1; m0_wdata = d0; m1_wdata = d1;
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         step();
         set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      end
   endtask

   initial begin
      mem_rdata = DB;
      dev_rdata = DV;
      reset = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Single-transfer table (locks low)
      vecs.push_back(mk(0,0,0,0, 0,0,0,0,                 0,0,4'b0000, 0,0, 0,0, 0,0));
      vecs.push_back(mk(1,0,0,0, 32'h10,0,0,0,            0,0,4'b0000, 0,0, 0,0, 0,0));
      vecs.push_back(mk(1,0,0,0, 32'h10,0,0,0,            1,0,4'b1000, 32'h10,0, 0,0, 0,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0,                 1,0,4'b0000, 0,0, 1,0, DB,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0,                 0,0,4'b0000, 0,0, 0,0, DB,0));
      vecs.push_back(mk(0,1,0,1, 0,32'h4000_0004,0,32'h55, 0,0,4'b0000, 0,0, 0,0, DB,0));
      vecs.push_back(mk(0,1,0,1, 0,32'h4000_0004,0,32'h55, 0,1,4'b0001, 32'h4000_0004,32'h55, 0,0, DB,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0,                 0,1,4'b0000, 0,0, 0,0, DB,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0,                 0,0,4'b0000, 0,0, 0,0, DB,0));
      vecs.push_back(mk(0,1,0,0, 0,32'h4000_0010,0,0,     0,0,4'b0000, 0,0, 0,0, DB,0));
      vecs.push_back(mk(0,1,0,0, 0,32'h4000_0010,0,0,     0,1,4'b0010, 32'h4000_0010,0, 0,0, DB,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0,                 0,1,4'b0000, 0,0, 0,1, DB,DV));
      vecs.push_back(mk(1,0,1,0, 32'h20,0,32'hA,0,        0,0,4'b0000, 0,0, 0,0, DB,DV));
      vecs.push_back(mk(1,0,1,0, 32'h20,0,32'hA,0,        1,0,4'b0100, 32'h20,32'hA, 0,0, DB,DV));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0,                 1,0,4'b0000, 0,0, 0,0, DB,DV));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0,                 0,0,4'b0000, 0,0, 0,0, DB,DV));
      vecs.push_back(mk(1,1,0,0, 32'h30,32'h4000_0030,0,0, 0,0,4'b0000, 0,0, 0,0, DB,DV));
`ifdef MEMBUS_ARB_PRIO_EN
      vecs.push_back(mk(1,1,0,0, 32'h30,32'h4000_0030,0,0, 1,0,4'b1000, 32'h30,0, 0,0, DB,DV));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0,                 1,0,4'b0000, 0,0, 1,0, DB,DV));
`else
      // M0 was granted most recently, so this tie goes to M1.
      vecs.push_back(mk(1,1,0,0, 32'h30,32'h4000_0030,0,0, 0,1,4'b0010, 32'h4000_0030,0, 0,0, DB,DV));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0,                 0,1,4'b0000, 0,0, 0,1, DB,DV));
`endif

      // Reset state
      step(); step();
      chk("rst.gnt", {m0_gnt, m1_gnt}, 2'b00);
      chk("rst.rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
      chk("rst.rdata0", m0_rdata, 0);
      chk("rst.rdata1", m1_rdata, 0);
      chk("rst.strb", {mem_read, mem_write, dev_read, dev_write}, 4'b0000);
      @(negedge clk);
      reset = 1'b1;

      foreach (vecs[i]) begin
         step();
         set_in(vecs[i].r0, vecs[i].r1, 0, 0, vecs[i].w0, vecs[i].w1,
                vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
         #3;
         chk($sformatf("v%0d.gnt0", i), m0_gnt, vecs[i].g0);
         chk($sformatf("v%0d.gnt1", i), m1_gnt, vecs[i].g1);
         chk($sformatf("v%0d.strb", i), {mem_read, mem_write, dev_read, dev_write}, vecs[i].strb);
         chk($sformatf("v%0d.baddr", i), bus_addr, vecs[i].baddr);
         chk($sformatf("v%0d.bwdata", i), bus_wdata, vecs[i].bwdata);
         chk($sformatf("v%0d.rvalid0", i), m0_rvalid, vecs[i].v0);
         chk($sformatf("v%0d.rvalid1", i), m1_rvalid, vecs[i].v1);
         chk($sformatf("v%0d.rdata0", i), m0_rdata, vecs[i].rd0);
         chk($sformatf("v%0d.rdata1", i), m1_rdata, vecs[i].rd1);
      end
      idle(2);

      // Fairness: both masters request continuously, no locks
      for (int i = 0; i < 25; i++) begin
         logic exp0;
         step();
         if (i == 0) set_in(1, 1, 0, 0, 0, 0, 32'h40, 32'h44, 0, 0);
         #3;
`ifdef MEMBUS_ARB_PRIO_EN
         exp0 = (((i - 1) % 9) < 8);
`else
         exp0 = ((((i - 1) / 8) % 2) == 0);
`endif
         if (i == 0) begin
            chk("fair.c0.gnt", {m0_gnt, m1_gnt}, 2'b00);
         end else begin
            chk($sformatf("fair.c%0d.gnt", i), {m0_gnt, m1_gnt}, {exp0, ~exp0});
            chk($sformatf("fair.c%0d.mem_read", i), mem_read, 1'b1);
         end
      end
      idle(2);

      // Locked M1 burst of 20 writes while M0 waits
      step();
      set_in(0, 1, 0, 1, 0, 1, 32'h50, 32'h100, 0, 32'h1000);
      #3;
      chk("lock.c0.gnt", {m0_gnt, m1_gnt}, 2'b00);
      for (int j = 0; j < 20; j++) begin
         step();
         set_in(1, 1, 0, 1, 0, 1, 32'h50, 32'h100, 0, 32'h1000 + j);
         #3;
         chk($sformatf("lock.b%0d.gnt", j), {m0_gnt, m1_gnt}, 2'b01);
         chk($sformatf("lock.b%0d.mem_write", j), mem_write, 1'b1);
         chk($sformatf("lock.b%0d.wdata", j), bus_wdata, 32'h1000 + j);
      end
      step();
      set_in(1, 0, 0, 0, 0, 0, 32'h50, 0, 0, 0);
      #3;
      chk("lock.drop.gnt", {m0_gnt, m1_gnt}, 2'b01);
      chk("lock.drop.strb", {mem_read, mem_write, dev_read, dev_write}, 4'b0000);
      step();
      #3;
      chk("lock.m0.gnt", {m0_gnt, m1_gnt}, 2'b10);
      chk("lock.m0.mem_read", mem_read, 1'b1);
      idle(2);

      // Unlocked M1 stream, M0 asks after three M1 transfers
      step();
      set_in(0, 1, 0, 0, 0, 0, 0, 32'h4000_0200, 0, 0);
      for (int j = 0; j < 3; j++) begin
         step();
         #3;
         chk($sformatf("pre.t%0d.gnt1", j), m1_gnt, 1'b1);
      end
      step();
      set_in(1, 1, 0, 0, 0, 0, 32'h60, 32'h4000_0200, 0, 0);
      #3;
      chk("pre.t3.gnt1", m1_gnt, 1'b1);
      chk("pre.t3.dev_read", dev_read, 1'b1);
      step();
      #3;
`ifdef MEMBUS_ARB_PRIO_EN
      chk("pre.next.gnt", {m0_gnt, m1_gnt}, 2'b10);
`else
      chk("pre.next.gnt", {m0_gnt, m1_gnt}, 2'b01);
`endif
      idle(3);

      // Async reset during an M0 read: response dropped, next tie to M0
      step();
      set_in(1, 0, 0, 0, 0, 0, 32'h10, 0, 0, 0);
      step();
      #3;
      chk("rstmid.gnt0", m0_gnt, 1'b1);
      chk("rstmid.mem_read", mem_read, 1'b1);
      reset = 1'b0;
      #1;
      chk("rstmid.async.gnt", {m0_gnt, m1_gnt}, 2'b00);
      chk("rstmid.async.strb", {mem_read, mem_write, dev_read, dev_write}, 4'b0000);
      step();
      chk("rstmid.rvalid0", m0_rvalid, 1'b0);
      chk("rstmid.rdata0", m0_rdata, 0);
      set_in(1, 1, 0, 0, 0, 0, 32'h70, 32'h74, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      step();
      #3;
      chk("rstmid.tie.gnt", {m0_gnt, m1_gnt}, 2'b10);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/membus_arbiter.md
Name: membus_arbiter

Overview:
Two-master arbiter for the shared data memory bus. Master 0 is the CPU data port; master 1 is a DMA/loader engine (e.g. a UART program loader). The block grants one master per cycle and splits each access between DataMemory and the device space by address. It returns registered read data to the master that issued the read. It sits between both masters and the existing DataMemory and device read/write strobes.

Parameters:
DATA_W, 32, data bus width
ADDR_W, 32, address width
MAX_HOLD, 8, transfers one owner may complete back-to-back before it must yield to a waiting master (ignored while that owner's lock is high)
MEM_LIMIT, 32'h40000000, addresses below this go to memory; addresses at or above it go to devices

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
mN_req  in  1  master N (N=0,1) requests a transfer; held until granted
mN_write  in  1  1 = write, 0 = read
mN_lock  in  1  keep ownership across consecutive transfers (burst)
mN_addr  in  ADDR_W  byte address
mN_wdata  in  DATA_W  write data
mN_gnt  out  1  registered grant; a transfer occurs in any cycle where mN_req && mN_gnt
mN_rvalid  out  1  read data valid, one cycle after the read transfer
mN_rdata  out  DATA_W  registered read data
mem_read, mem_write  out  1  DataMemory strobes
dev_read, dev_write  out  1  device strobes
bus_addr  out  ADDR_W  muxed address
bus_wdata  out  DATA_W  muxed write data
mem_rdata  in  DATA_W  DataMemory read data, combinational
dev_rdata  in  DATA_W  device read data, combinational

Behaviour:
- State owner ∈ {NONE, M0, M1}. mN_gnt = (owner==MN), driven from a register.
- Reset (reset==0, async) forces: owner=NONE, all gnt=0, all rvalid=0, all rdata=0, hold_cnt=0, rr_last=M1 (so M0 wins the first tie).
- Transfer cycle: owner's req high. bus_addr/bus_wdata come from the owner. Strobes are combinational:
  - mem_* asserted when bus_addr < MEM_LIMIT; dev_* asserted otherwise.
  - read strobe when !write; write strobe when write.
  - With no transfer, all strobes are 0 and bus_addr/bus_wdata are 0.
- Next-owner rule at each posedge (X = current owner, Y = other master):
  - X keeps ownership if req_X && (lock_X || !req_Y || hold_cnt < MAX_HOLD).
  - Otherwise ownership goes to Y if req_Y.
  - Otherwise owner becomes NONE.
  - From NONE with both requesting, the winner is the master that is not rr_last.
  - On every ownership change, rr_last = new owner and hold_cnt is cleared to 0.
- hold_cnt increments on each completed transfer by the same owner and saturates at MAX_HOLD.
- Grant latency: req rises at edge k, gnt is high after edge k+1, and the first transfer occurs in that cycle. Back-to-back transfers then run at 1 per cycle while ownership holds.
- Read response: on a read transfer, rdata is latched at the next edge from mem_rdata or dev_rdata (selected by the same address decode). mN_rvalid is a 1-cycle pulse on the owner of that read. rdata holds its value otherwise.
- Writes produce no response.
- If the owner drops req while granted, no transfer occurs. gnt falls at the next edge, or moves to Y.
- Both masters locked: the current owner keeps the bus. Lock has no effect unless the master already owns the bus.
- Reset asserted mid-transfer: the pending rvalid is discarded and the bus is idle immediately (strobes depend on gnt, which is reset).

Optional Feature:
MEMBUS_ARB_PRIO_EN
- Defined: fixed priority. M0 wins every tie. If M0 requests and M1 owns the bus without m1_lock, ownership moves to M0 at the next edge regardless of hold_cnt. M1 is never preempted while m1_lock is high. MAX_HOLD applies only to M0.
- Undefined: round-robin with MAX_HOLD fairness, as above.

Decomposition:
- Package membus_pkg: owner encoding (NONE=2'b00, M0=2'b01, M1=2'b10) and default MEM_LIMIT 32'h40000000. The CPU uses the same MEM_LIMIT constant.
- Sub-module membus_route: combinational address decode, strobe generation and read-data select. Instantiated once.
- FSM, counters and response registers live in membus_arbiter.

Test Plan:
- Reset then M0 read at 0x00000010 (mem_rdata=0xDEADBEEF) → m0_gnt 1 cycle after req; mem_read=1 for 1 cycle; m0_rvalid=1 with m0_rdata=0xDEADBEEF the next cycle; dev_* stay 0.
- M1 write 0x40000004 data 0x55 → dev_write=1, bus_addr=0x40000004, bus_wdata=0x55; mem_write=0; no rvalid.
- M0 and M1 both request continuously, locks 0, MAX_HOLD=8 → grant sequence is M0×8, M1×8, M0×8; hold_cnt cleared at each switch.
- M1 holds lock for a 20-word burst while M0 requests → M1 keeps gnt for all 20 transfers; M0 is granted the edge after m1_req falls.
- Reset pulled low one cycle after an M0 read transfer → m0_rvalid stays 0, all gnt=0 asynchronously; after release, first tie goes to M0.
- With MEMBUS_ARB_PRIO_EN, M1 unlocked mid-stream and M0 raises req → M0 owns the bus after exactly one edge; with m1_lock=1, M0 waits until M1 releases.
